// File: rtl/uart_buffer_pkg.sv
// Shared constants and types for the uart_buffer slice.
// The data width is fixed at 8 to match the uart block's byte-wide FIFO port.
package uart_buffer_pkg;

   localparam int unsigned DATA_W = 8;

   typedef logic [DATA_W-1:0] byte_t;

endpackage : uart_buffer_pkg

// File: rtl/uart_buffer_sfifo.sv
// sfifo: synchronous show-ahead FIFO with register-array storage.
// Ports:
//   clk, arstn   clock and asynchronous active-low reset
//   push, din    enqueue strobe and data (accepted when not full, or when a pop is taken the same cycle)
//   pop          dequeue strobe (ignored when empty)
//   dout         head entry, valid while empty=0
//   count        occupancy 0..2**ALOG2
//   full, empty  registered occupancy flags
module sfifo
   import uart_buffer_pkg::*;
#(
   parameter int unsigned ALOG2 = 4
) (
   input  logic             clk,
   input  logic             arstn,
   input  logic             push,
   input  logic [7:0]       din,
   input  logic             pop,
   output logic [7:0]       dout,
   output logic [ALOG2:0]   count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned DEPTH = 2**ALOG2;
   localparam int unsigned CW    = ALOG2 + 1;

   byte_t            mem [DEPTH];
   logic [ALOG2-1:0] wr_ptr;
   logic [ALOG2-1:0] rd_ptr;
   logic             do_pop_c;
   logic             do_push_c;
   logic [ALOG2:0]   count_nxt_c;

   // A pop taken this cycle frees the slot a push into a full FIFO needs.
   always_comb begin
      do_pop_c    = pop && !empty;
      do_push_c   = push && (!full || do_pop_c);
      count_nxt_c = count + CW'(do_push_c) - CW'(do_pop_c);
   end

   // Pointers, occupancy and flags; flags follow the next count so they stay registered.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push_c) wr_ptr <= wr_ptr + ALOG2'(1);
         if (do_pop_c)  rd_ptr <= rd_ptr + ALOG2'(1);
         count <= count_nxt_c;
         full  <= (count_nxt_c == CW'(DEPTH));
         empty <= (count_nxt_c == '0);
      end
   end

   // Storage needs no reset; occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push_c) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule : sfifo

// File: rtl/uart_buffer.sv
// uart_buffer: host-side TX/RX FIFOs in front of the uart block's FIFO-compatible port.
// Ports:
//   clk, arstn                 clock and asynchronous active-low reset
//   tx_push, tx_data           host byte enqueue into the TX FIFO
//   tx_full, tx_count          TX FIFO status
//   rx_pop, rx_data            host dequeue from the RX FIFO (show-ahead head)
//   rx_empty, rx_count         RX FIFO status
//   err, err_clr               sticky {rx_overrun, tx_overflow}, cleared by err_clr
//   u_ready, u_wr, u_din       UART transmit side (u_wr/u_din registered)
//   u_full, u_rd, u_dout       UART receive side (u_rd registered)
module uart_buffer
   import uart_buffer_pkg::*;
#(
   parameter int unsigned ALOG2 = 4
) (
   input  logic             clk,
   input  logic             arstn,
   input  logic             tx_push,
   input  logic [7:0]       tx_data,
   output logic             tx_full,
   output logic [ALOG2:0]   tx_count,
   input  logic             rx_pop,
   output logic [7:0]       rx_data,
   output logic             rx_empty,
   output logic [ALOG2:0]   rx_count,
   output logic [1:0]       err,
   input  logic             err_clr,
   input  logic             u_ready,
   output logic             u_wr,
   output logic [7:0]       u_din,
   input  logic             u_full,
   output logic             u_rd,
   input  logic [7:0]       u_dout
);

   byte_t tx_head;
   logic  tx_empty;
   logic  rx_full;
   logic  tx_pop_c;
   logic  rx_cap_c;
   logic  tx_drop_c;
   logic  rx_drop_c;

   sfifo #(.ALOG2(ALOG2)) u_tx_fifo (
      .clk   (clk),
      .arstn (arstn),
      .push  (tx_push),
      .din   (tx_data),
      .pop   (tx_pop_c),
      .dout  (tx_head),
      .count (tx_count),
      .full  (tx_full),
      .empty (tx_empty)
   );

   sfifo #(.ALOG2(ALOG2)) u_rx_fifo (
      .clk   (clk),
      .arstn (arstn),
      .push  (rx_cap_c),
      .din   (u_dout),
      .pop   (rx_pop),
      .dout  (rx_data),
      .count (rx_count),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // u_wr/u_rd gating holds off a second strobe until the UART has seen the first.
   always_comb begin
      tx_pop_c  = !tx_empty && u_ready && !u_wr;
      rx_cap_c  = u_full && !u_rd;
      tx_drop_c = tx_push && tx_full && !tx_pop_c;
      rx_drop_c = rx_cap_c && rx_full && !rx_pop;
   end

   // Drain/capture strobes and sticky errors; new error events win over err_clr.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         u_wr  <= 1'b0;
         u_din <= '0;
         u_rd  <= 1'b0;
         err   <= '0;
      end else begin
         u_wr <= tx_pop_c;
         if (tx_pop_c) u_din <= tx_head;
         u_rd <= rx_cap_c;
         err  <= (err_clr ? 2'b00 : err) | {rx_drop_c, tx_drop_c};
      end
   end

endmodule : uart_buffer

// File: tb/tb_uart_buffer.sv
// Randomized bench for uart_buffer: queue-based reference model of both FIFOs,
// plus simple UART models (ready drops one clk after wr for 10 clk; full clears one clk after rd).
module tb_uart_buffer;

   localparam int unsigned ALOG2 = 4;
   localparam int DEPTH = 16;

   logic         clk = 1'b0;
   logic         arstn;
   logic         tx_push;
   logic [7:0]   tx_data;
   logic         tx_full;
   logic [ALOG2:0] tx_count;
   logic         rx_pop;
   logic [7:0]   rx_data;
   logic         rx_empty;
   logic [ALOG2:0] rx_count;
   logic [1:0]   err;
   logic         err_clr;
   logic         u_ready;
   logic         u_wr;
   logic [7:0]   u_din;
   logic         u_full;
   logic         u_rd;
   logic [7:0]   u_dout;

   always #5 clk = ~clk;

   uart_buffer #(.ALOG2(ALOG2)) dut (
      .clk      (clk),
      .arstn    (arstn),
      .tx_push  (tx_push),
      .tx_data  (tx_data),
      .tx_full  (tx_full),
      .tx_count (tx_count),
      .rx_pop   (rx_pop),
      .rx_data  (rx_data),
      .rx_empty (rx_empty),
      .rx_count (rx_count),
      .err      (err),
      .err_clr  (err_clr),
      .u_ready  (u_ready),
      .u_wr     (u_wr),
      .u_din    (u_din),
      .u_full   (u_full),
      .u_rd     (u_rd),
      .u_dout   (u_dout)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0] tx_q [$];
   logic [7:0] rx_q [$];
   logic [7:0] dir_tx [$];
   logic [7:0] dir_rx [$];
   logic       m_wr = 1'b0;
   logic       m_rd = 1'b0;
   logic [7:0] m_din = 8'h00;
   logic [1:0] m_err = 2'b00;
   int         tx_busy = 0;
   logic       src_full = 1'b0;
   logic [7:0] src_byte = 8'h00;

   // Stimulus knobs (percentages)
   int push_pct = 0;
   int pop_pct  = 0;
   int clr_pct  = 0;
   int src_pct  = 0;
   logic ready_en  = 1'b1;
   logic force_clr = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("tx_count", 32'(tx_count), 32'(tx_q.size()));
      check("tx_full",  32'(tx_full),  32'(tx_q.size() == DEPTH));
      check("rx_count", 32'(rx_count), 32'(rx_q.size()));
      check("rx_empty", 32'(rx_empty), 32'(rx_q.size() == 0));
      if (rx_q.size() > 0) check("rx_data", 32'(rx_data), 32'(rx_q[0]));
      check("err",  32'(err),  32'(m_err));
      check("u_wr", 32'(u_wr), 32'(m_wr));
      if (m_wr) check("u_din", 32'(u_din), 32'(m_din));
      check("u_rd", 32'(u_rd), 32'(m_rd));
   endtask

   // Drive inputs for the coming posedge and advance the model across that edge.
   task automatic drive_and_step();
      logic tx_pop, set0, cap, pop_ok, set1;
      u_ready = ready_en && (tx_busy == 0);
      u_full  = src_full;
      u_dout  = src_byte;
      if (dir_tx.size() > 0) begin
         tx_push = 1'b1;
         tx_data = dir_tx.pop_front();
      end else begin
         tx_push = ($urandom_range(99) < push_pct);
         tx_data = 8'($urandom);
      end
      rx_pop    = ($urandom_range(99) < pop_pct);
      err_clr   = force_clr || ($urandom_range(99) < clr_pct);
      force_clr = 1'b0;

      // TX FIFO and drain
      tx_pop = (tx_q.size() > 0) && u_ready && !m_wr;
      set0   = tx_push && (tx_q.size() == DEPTH) && !tx_pop;
      if (tx_pop) m_din = tx_q.pop_front();
      if (tx_push && !set0) tx_q.push_back(tx_data);

      // RX capture and host pop
      cap    = src_full && !m_rd;
      pop_ok = rx_pop && (rx_q.size() > 0);
      set1   = cap && (rx_q.size() == DEPTH) && !pop_ok;
      if (pop_ok) void'(rx_q.pop_front());
      if (cap && !set1) rx_q.push_back(src_byte);

      m_err = (err_clr ? 2'b00 : m_err) | {set1, set0};

      // UART models react to the strobes they see at this edge
      if (m_wr) tx_busy = 10;
      else if (tx_busy > 0) tx_busy--;
      if (m_rd) src_full = 1'b0;
      else if (!src_full) begin
         if (dir_rx.size() > 0) begin
            src_full = 1'b1;
            src_byte = dir_rx.pop_front();
         end else if ($urandom_range(99) < src_pct) begin
            src_full = 1'b1;
            src_byte = 8'($urandom);
         end
      end

      m_wr = tx_pop;
      m_rd = cap;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         check_outputs();
         drive_and_step();
      end
   endtask

   task automatic idle_inputs();
      tx_push = 1'b0; tx_data = 8'h00; rx_pop = 1'b0; err_clr = 1'b0;
      u_ready = 1'b0; u_full = 1'b0; u_dout = 8'h00;
   endtask

   initial begin
      logic got_wr;
      arstn = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      check_outputs();
      arstn = 1'b1;

      // Three bytes out with the UART ready
      dir_tx.push_back(8'h55); dir_tx.push_back(8'hAA); dir_tx.push_back(8'h0F);
      ready_en = 1'b1; push_pct = 0; pop_pct = 0; src_pct = 0;
      run(60);

      // TX overflow with the UART stalled, then clear
      ready_en = 1'b0; push_pct = 100;
      run(20);
      push_pct = 0; force_clr = 1'b1;
      run(3);

      // Two received bytes, then pop one
      ready_en = 1'b1;
      run(200);
      dir_rx.push_back(8'h41); dir_rx.push_back(8'h42);
      run(10);
      pop_pct = 100;
      run(1);
      pop_pct = 0;
      run(3);

      // Fill RX and overrun, head must stay put
      dir_rx.push_back(8'h99);
      src_pct = 100;
      run(90);

      // Pops racing captures on a full RX FIFO
      pop_pct = 35;
      run(60);

      // Mixed random traffic
      repeat (20) begin
         push_pct = $urandom_range(100);
         pop_pct  = $urandom_range(100);
         clr_pct  = $urandom_range(10);
         src_pct  = $urandom_range(100);
         ready_en = ($urandom_range(3) != 0);
         run(100);
      end

      // Async reset while holding data and with a u_wr pulse active
      push_pct = 60; pop_pct = 5; clr_pct = 0; src_pct = 100; ready_en = 1'b1;
      got_wr = 1'b0;
      for (int i = 0; i < 400; i++) begin
         run(1);
         if (m_wr && tx_q.size() > 0 && rx_q.size() > 0) begin
            got_wr = 1'b1;
            break;
         end
      end
      check("wr_wait", 32'(got_wr), 32'd1);
      @(posedge clk);
      #2;
      if (got_wr) check("pre_rst_wr", 32'(u_wr), 32'd1);
      arstn = 1'b0;
      idle_inputs();
      #1;
      tx_q.delete(); rx_q.delete(); dir_tx.delete(); dir_rx.delete();
      m_wr = 1'b0; m_rd = 1'b0; m_err = 2'b00; tx_busy = 0; src_full = 1'b0;
      check("rst_u_wr",     32'(u_wr),     32'd0);
      check("rst_u_rd",     32'(u_rd),     32'd0);
      check("rst_tx_count", 32'(tx_count), 32'd0);
      check("rst_rx_count", 32'(rx_count), 32'd0);
      check("rst_rx_empty", 32'(rx_empty), 32'd1);
      check("rst_tx_full",  32'(tx_full),  32'd0);
      check("rst_err",      32'(err),      32'd0);
      @(negedge clk);
      arstn = 1'b1;

      // Random traffic after reset
      push_pct = 50; pop_pct = 50; clr_pct = 3; src_pct = 50;
      run(300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_uart_buffer
